// File: rtl/lsu_ctrl.sv
// Load/store unit: one byte/halfword/word access per request on a req/ack memory port,
// with lane steering, load extension, alignment/funct3 checks and a bus timeout.
module lsu_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_lsu_valid,
  input  logic             i_lsu_wren,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_lsu_addr,
  input  logic [WIDTH-1:0] i_st_data,
  output logic             o_lsu_ready,
  output logic             o_lsu_done,
  output logic [1:0]       o_lsu_err,
  output logic [WIDTH-1:0] o_ld_data,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic [3:0]       o_mem_bmask,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic             i_mem_ack,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrIllegal  = 2'b10;
  localparam logic [1:0] ErrTimeout  = 2'b11;

  // Timeout fires on the last counted REQ cycle, so REQ lasts exactly TIMEOUT_CYC cycles.
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] ld_data_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [3:0]       mem_bmask_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic             mem_we_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;

  logic             accept;
  logic             f3_illegal;
  logic             misaligned;
  logic [1:0]       acc_err;
  logic [3:0]       acc_bmask;
  logic [WIDTH-1:0] acc_wdata;
  logic [WIDTH-1:0] rd_shift;
  logic [WIDTH-1:0] ld_ext;

  assign accept = (state_q == StIdle) && i_lsu_valid;

  // Access checks on the incoming request
  always_comb begin
    f3_illegal = 1'b0;
    misaligned = 1'b0;
    case (i_funct3)
      3'b000:         misaligned = 1'b0;
      3'b001, 3'b101: misaligned = i_lsu_addr[0];
      3'b010:         misaligned = |i_lsu_addr[1:0];
      3'b100:         misaligned = 1'b0;
      default:        f3_illegal = 1'b1;
    endcase
    if (i_funct3[2] && i_lsu_wren) begin
      f3_illegal = 1'b1;
    end
    if (f3_illegal) begin
      acc_err = ErrIllegal;
    end else if (misaligned) begin
      acc_err = ErrMisalign;
    end else begin
      acc_err = ErrOk;
    end
  end

  // Lane steering for the incoming request
  always_comb begin
    acc_bmask = 4'b1111;
    acc_wdata = i_st_data;
    case (i_funct3[1:0])
      2'b00: begin
        acc_bmask = 4'b0001 << i_lsu_addr[1:0];
        acc_wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        acc_bmask = 4'b0011 << i_lsu_addr[1:0];
        acc_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        acc_bmask = 4'b1111;
        acc_wdata = i_st_data;
      end
    endcase
  end

  // Load alignment and extension
  always_comb begin
    rd_shift = i_mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'd0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (i_lsu_valid) begin
          err_d   = acc_err;
          cnt_d   = 8'd0;
          state_d = (acc_err != ErrOk) ? StDone : StReq;
        end
      end
      StReq: begin
        if (i_mem_ack) begin
          err_d   = ErrOk;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = ErrTimeout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      err_q   <= ErrOk;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request registers hold steady through REQ because they only load on accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_addr_q  <= '0;
      mem_bmask_q <= 4'b0000;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
    end else if (accept) begin
      mem_addr_q  <= {i_lsu_addr[WIDTH-1:2], 2'b00};
      mem_bmask_q <= acc_bmask;
      mem_wdata_q <= acc_wdata;
      mem_we_q    <= i_lsu_wren;
      funct3_q    <= i_funct3;
      off_q       <= i_lsu_addr[1:0];
    end
  end

  // Cleared on every accept, so stores, errors and timeouts all leave zero behind
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ld_data_q <= '0;
    end else if (accept) begin
      ld_data_q <= '0;
    end else if ((state_q == StReq) && i_mem_ack && !mem_we_q) begin
      ld_data_q <= ld_ext;
    end
  end

  assign o_lsu_ready = (state_q == StIdle);
  assign o_lsu_done  = (state_q == StDone);
  assign o_mem_req   = (state_q == StReq);
  assign o_lsu_err   = err_q;
  assign o_ld_data   = ld_data_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule
